// File: rtl/prog_loader_if.sv
// rtl/prog_loader_if.sv - word stream and memory write bus of the program loader
//
// Groups the upstream word stream (in_valid/in_data/in_last/in_ready) and the
// memory write port (mem_we/mem_addr/mem_wdata).
//   master : upstream word source / memory observer
//   slave  : the loader (consumes words, drives memory writes)
interface prog_loader_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    modport master (
        output in_valid, in_data, in_last,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - streams program words into core memory and releases the core
//
// Ports:
//   clk        loader clock, all logic on posedge
//   rst        asynchronous active-high reset
//   start      1-cycle pulse, begins a load at base_addr (ignored while loading)
//   base_addr  first write address, sampled when start is accepted
//   ldr        slave side of prog_loader_if: word stream in, memory write out
//   cpu_hold   1 keeps the core halted; drops one cycle after the final write
//   load_done  sticky, program loaded successfully
//   load_err   sticky, address space exhausted before the last word
//   word_count words written in the current load
module prog_loader #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    prog_loader_if.slave      ldr,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   word_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] TOP_ADDR = '1;

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] ptr;
    logic              accept;
    logic              restart;

    assign ldr.in_ready = (state == LOAD);
    assign accept       = ldr.in_valid && ldr.in_ready;
    // start is only honoured outside LOAD
    assign restart      = start && (state != LOAD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = LOAD;
                end
            end
            LOAD: begin
                if (accept) begin
                    // last word at the top address is a clean finish, not an overflow
                    if (ldr.in_last) begin
                        state_nx = DONE;
                    end else if (ptr == TOP_ADDR) begin
                        state_nx = ERR;
                    end
                end
            end
            DONE, ERR: begin
                if (start) begin
                    state_nx = LOAD;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ldr.mem_we    <= 1'b0;
            ldr.mem_addr  <= '0;
            ldr.mem_wdata <= '0;
            ptr           <= '0;
            word_count    <= '0;
            load_done     <= 1'b0;
            load_err      <= 1'b0;
            cpu_hold      <= 1'b1;
        end else begin
            // one write per accepted beat, exactly one cycle later
            ldr.mem_we <= accept;
            if (accept) begin
                ldr.mem_addr  <= ptr;
                ldr.mem_wdata <= ldr.in_data;
                word_count    <= word_count + 1'b1;
                // saturate at the top address; overflow ends the load anyway
                if (ptr != TOP_ADDR) begin
                    ptr <= ptr + 1'b1;
                end
            end
            if (restart) begin
                ptr        <= base_addr;
                word_count <= '0;
            end
            // flags track the state being entered, so they rise with the final
            // write and clear on the start edge
            load_done <= (state_nx == DONE);
            load_err  <= (state_nx == ERR);
            // registered from the current state: the release lands one cycle
            // after the final write strobe
            cpu_hold  <= !((state == DONE) && !start);
        end
    end

endmodule
